// File: rtl/ctdsm_pkg.sv
// ============================================================================
// ctdsm_pkg : shared constants and types for the CT delta-sigma decimator.
// Macro CTDSM_DEC_SINC3_EN selects a third-order CIC (default: second order).
// Revision: 1.0
// ============================================================================
`default_nettype none

package ctdsm_pkg;

  localparam int OUT_W_DEF = 16;

`ifdef CTDSM_DEC_SINC3_EN
  localparam int CIC_N = 3;
`else
  localparam int CIC_N = 2;
`endif

  // One sign bit plus N*log2(Rmax) bits holds 128^N without ambiguity.
  localparam int DW    = 1 + 7 * CIC_N;
  localparam int CNT_W = 7;

  typedef enum logic [1:0] {
    DEC_16  = 2'd0,
    DEC_32  = 2'd1,
    DEC_64  = 2'd2,
    DEC_128 = 2'd3
  } ratio_sel_e;

  typedef enum logic {
    ST_FLUSH = 1'b0,
    ST_RUN   = 1'b1
  } dec_state_e;

  // Indexed by dec_sel: log2 of the decimation ratio.
  localparam logic [3:0][2:0] LOG2R_TBL = {3'd7, 3'd6, 3'd5, 3'd4};

endpackage

`default_nettype wire

// File: rtl/ctdsm_sync2.sv
// ============================================================================
// ctdsm_sync2 : two-flop synchronizer for the comparator bit, frozen by ena.
// Revision: 1.0
// ============================================================================
`default_nettype none

module ctdsm_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic d,
  output logic q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else if (ena) begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule

`default_nettype wire

// File: rtl/ctdsm_decimator.sv
// ============================================================================
// ctdsm_decimator : CIC decimator (order 2, or 3 with CTDSM_DEC_SINC3_EN)
// for a 1-bit CT delta-sigma stream, with valid/ready output and overrun flag.
// Revision: 1.0
// ============================================================================
`default_nettype none

module ctdsm_decimator
  import ctdsm_pkg::*;
#(
  parameter int OUT_W = OUT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             bit_in,
  input  logic [1:0]       dec_sel,
  output logic [OUT_W-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             overrun,
  input  logic             clr_ovr
);

  localparam int SW = (DW > OUT_W + 1) ? DW : OUT_W + 1;

  logic             w_bit;
  ratio_sel_e       r_sel;
  logic             w_sel_chg;
  dec_state_e       r_state;
  logic [1:0]       r_disc;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_rm1;
  logic             w_last;
  logic [DW-1:0]    r_int1, r_int2, w_int_n;
  logic [DW-1:0]    r_dly1, r_dly2, w_c1, w_c2, w_comb, r_comb;
`ifdef CTDSM_DEC_SINC3_EN
  logic [DW-1:0]    r_int3, r_dly3, w_c3;
`endif
  logic             r_emit;
  logic [OUT_W-1:0] r_dout;
  logic             r_valid;
  logic             r_ovr;
  int               w_nl;
  logic [SW-1:0]    w_sx;
  logic [OUT_W-1:0] w_dnext;

  ctdsm_sync2 u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .d     (bit_in),
    .q     (w_bit)
  );

  assign w_sel_chg = (dec_sel != r_sel);
  assign w_rm1     = CNT_W'((8'd1 << LOG2R_TBL[r_sel]) - 8'd1);
  assign w_last    = (r_cnt == w_rm1);

  // Comb chain is evaluated combinationally; only its delay taps are stored.
  assign w_c1 = w_int_n - r_dly1;
  assign w_c2 = w_c1 - r_dly2;
`ifdef CTDSM_DEC_SINC3_EN
  assign w_int_n = r_int3;
  assign w_c3    = w_c2 - r_dly3;
  assign w_comb  = w_c3;
`else
  assign w_int_n = r_int2;
  assign w_comb  = w_c2;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel   <= DEC_16;
      r_state <= ST_FLUSH;
      r_disc  <= '0;
      r_cnt   <= '0;
      r_int1  <= '0;
      r_int2  <= '0;
      r_dly1  <= '0;
      r_dly2  <= '0;
      r_comb  <= '0;
      r_emit  <= 1'b0;
`ifdef CTDSM_DEC_SINC3_EN
      r_int3  <= '0;
      r_dly3  <= '0;
`endif
    end else begin
      r_sel  <= ratio_sel_e'(dec_sel);
      r_emit <= 1'b0;
      if (w_sel_chg) begin
        r_state <= ST_FLUSH;
        r_disc  <= '0;
        r_cnt   <= '0;
        r_int1  <= '0;
        r_int2  <= '0;
        r_dly1  <= '0;
        r_dly2  <= '0;
        r_comb  <= '0;
`ifdef CTDSM_DEC_SINC3_EN
        r_int3  <= '0;
        r_dly3  <= '0;
`endif
      end else if (!ena) begin
        r_state <= ST_FLUSH;
        r_disc  <= '0;
      end else begin
        r_int1 <= r_int1 + DW'(w_bit);
        r_int2 <= r_int2 + r_int1;
`ifdef CTDSM_DEC_SINC3_EN
        r_int3 <= r_int3 + r_int2;
        r_dly3 <= w_last ? w_c2 : r_dly3;
`endif
        if (w_last) begin
          r_cnt  <= '0;
          r_dly1 <= w_int_n;
          r_dly2 <= w_c1;
          r_comb <= w_comb;
          if (r_state == ST_RUN) begin
            r_emit <= 1'b1;
          end else if (r_disc == 2'(CIC_N - 1)) begin
            r_state <= ST_RUN;
          end else begin
            r_disc <= r_disc + 2'd1;
          end
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
    end
  end

  // Full scale R^N maps onto 2^OUT_W, which is one code too many and is clipped.
  always_comb begin
    w_nl    = CIC_N * int'(LOG2R_TBL[r_sel]);
    w_sx    = '0;
    w_dnext = '0;
    if (w_nl <= OUT_W) begin
      w_sx = SW'(r_comb) << (OUT_W - w_nl);
    end else begin
      w_sx = SW'(r_comb) >> (w_nl - OUT_W);
    end
    w_dnext = (|w_sx[SW-1:OUT_W]) ? '1 : w_sx[OUT_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dout  <= '0;
      r_valid <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_ovr <= (r_emit & r_valid & ~dout_ready) | (r_ovr & ~clr_ovr);
      if (r_emit) begin
        r_dout  <= w_dnext;
        r_valid <= 1'b1;
      end else if (dout_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign dout       = r_dout;
  assign dout_valid = r_valid;
  assign overrun    = r_ovr;

endmodule

`default_nettype wire

// File: tb/tb_ctdsm_decimator.sv
// ============================================================================
// tb_ctdsm_decimator : self-checking bench for ctdsm_decimator using periodic
// bit patterns whose decimated value follows directly from their ones-density.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_ctdsm_decimator;
  import ctdsm_pkg::*;

  localparam int OW = 16;
  localparam int N  = CIC_N;

  logic          clk = 1'b0;
  logic          rst_n, ena, bit_in, dout_ready, clr_ovr;
  logic [1:0]    dec_sel;
  logic [OW-1:0] dout;
  logic          dout_valid, overrun;

  int            tests, fails;
  logic [15:0]   pat;
  int            idx;
  int            cyc, nv, rr;
  logic [15:0]   p2;

  ctdsm_decimator #(.OUT_W(OW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .bit_in     (bit_in),
    .dec_sel    (dec_sel),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .overrun    (overrun),
    .clr_ovr    (clr_ovr)
  );

  always #5 clk = ~clk;

  // A stream periodic in 16 with k ones gives a CIC output of exactly R^N*k/16,
  // i.e. k*2^(OUT_W-4) after scaling, clipped at full scale.
  function automatic logic [15:0] exp_val(input logic [15:0] p);
    int k;
    k = $countones(p);
    if (k * 4096 > 65535) return 16'hFFFF;
    return 16'(k * 4096);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rng(input string tag, input int val, input int lo, input int hi);
    tests++;
    assert (val > lo && val <= hi) else begin
      fails++;
      $error("FAIL %s: observed %0d expected in (%0d,%0d]", tag, val, lo, hi);
    end
  endtask

  task automatic set_pat(input logic [15:0] p);
    pat    = p;
    bit_in = pat[idx % 16];
  endtask

  // The pattern index only advances on edges the synchronizer actually samples.
  task automatic tick();
    @(posedge clk);
    if (ena && rst_n) idx++;
    #1;
    bit_in = pat[idx % 16];
  endtask

  task automatic wait_valid(input string tag, input int budget, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!dout_valid && n < budget);
    chk(tag, 32'(dout_valid), 32'd1);
  endtask

  initial begin
    tests = 0; fails = 0; idx = 0; pat = '0;
    rst_n = 1'b0; ena = 1'b0; bit_in = 1'b0; dec_sel = 2'd0;
    dout_ready = 1'b1; clr_ovr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_dout", 32'(dout), 32'd0);
    chk("rst_valid", 32'(dout_valid), 32'd0);
    chk("rst_ovr", 32'(overrun), 32'd0);

    // Constant ones at R=16: clip path, one sample per 16 clocks.
    set_pat(16'hFFFF); ena = 1'b1; rst_n = 1'b1;
    wait_valid("ones_first", (N + 1) * 16 + 8, cyc);
    chk_rng("ones_flush", cyc, N * 16, (N + 1) * 16 + 3);
    chk("ones_clip", 32'(dout), 32'hFFFF);
    repeat (3) begin
      wait_valid("ones_next", 24, cyc);
      chk("ones_period", 32'(cyc), 32'd16);
      chk("ones_val", 32'(dout), 32'hFFFF);
    end

    // Constant zeros at R=128.
    set_pat(16'h0000); dec_sel = 2'd3;
    wait_valid("zero_first", (N + 1) * 128 + 8, cyc);
    chk_rng("zero_flush", cyc, N * 128, (N + 1) * 128 + 3);
    chk("zero_val", 32'(dout), 32'h0);
    wait_valid("zero_next", 140, cyc);
    chk("zero_period", 32'(cyc), 32'd128);
    chk("zero_val2", 32'(dout), 32'h0);
    chk("zero_novr", 32'(overrun), 32'd0);

    // Alternating bits at R=32: exact mid-scale.
    set_pat(16'h5555); dec_sel = 2'd1;
    wait_valid("alt_first", (N + 1) * 32 + 8, cyc);
    chk("alt_val", 32'(dout), 32'h8000);
    wait_valid("alt_next", 40, cyc);
    chk("alt_val2", 32'(dout), 32'h8000);

    // Ratio change 16 -> 64 in mid-frame.
    set_pat(16'($urandom)); dec_sel = 2'd0;
    wait_valid("sw_pre", (N + 1) * 16 + 8, cyc);
    repeat (5) tick();
    dec_sel = 2'd2;
    wait_valid("sw_first", (N + 1) * 64 + 8, cyc);
    chk_rng("sw_flush", cyc, N * 64, (N + 1) * 64 + 3);
    chk("sw_val", 32'(dout), 32'(exp_val(pat)));

    // Random densities and ratios; every ratio change restarts the filter.
    repeat (5) begin
      set_pat(16'($urandom));
      dec_sel = 2'((int'(dec_sel) + 1 + int'($urandom_range(0, 2))) % 4);
      rr = 16 << dec_sel;
      wait_valid("rnd_first", (N + 1) * rr + 8, cyc);
      chk_rng("rnd_flush", cyc, N * rr, (N + 1) * rr + 3);
      chk("rnd_val", 32'(dout), 32'(exp_val(pat)));
      wait_valid("rnd_next", rr + 4, cyc);
      chk("rnd_period", 32'(cyc), 32'(rr));
      chk("rnd_val2", 32'(dout), 32'(exp_val(pat)));
    end

    // Disable: no output while frozen, then a fresh flush on re-enable.
    ena = 1'b0; nv = 0;
    repeat (3 * rr) begin
      tick();
      if (dout_valid) nv++;
    end
    chk("ena_quiet", 32'(nv), 32'd0);
    ena = 1'b1;
    wait_valid("ena_first", (N + 1) * rr + 8, cyc);
    chk_rng("ena_flush", cyc, N * rr, (N + 1) * rr + 1);
    chk("ena_val", 32'(dout), 32'(exp_val(pat)));

    // Handshake and overrun at R=16.
    p2 = 16'($urandom);
    set_pat(p2); dec_sel = 2'd1;
    tick();
    dec_sel = 2'd0;
    wait_valid("hs_first", (N + 1) * 16 + 8, cyc);
    dout_ready = 1'b0;
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (!overrun && cyc < 24);
    chk("ovr_set", 32'(overrun), 32'd1);
    chk("ovr_spacing", 32'(cyc), 32'd16);
    chk("ovr_valid", 32'(dout_valid), 32'd1);
    chk("ovr_latest", 32'(dout), 32'(exp_val(p2)));
    clr_ovr = 1'b1;
    tick();
    clr_ovr = 1'b0;
    chk("ovr_clr", 32'(overrun), 32'd0);
    chk("hold_valid", 32'(dout_valid), 32'd1);
    repeat (14) tick();
    chk("hold_dout", 32'(dout), 32'(exp_val(p2)));
    dout_ready = 1'b1;
    tick();
    chk("acc_same_valid", 32'(dout_valid), 32'd1);
    chk("acc_same_novr", 32'(overrun), 32'd0);
    tick();
    chk("acc_drop", 32'(dout_valid), 32'd0);
    dout_ready = 1'b0;
    repeat (15) tick();
    chk("load_valid", 32'(dout_valid), 32'd1);
    chk("load_novr", 32'(overrun), 32'd0);
    repeat (15) tick();
    clr_ovr = 1'b1;
    tick();
    clr_ovr = 1'b0;
    chk("set_wins", 32'(overrun), 32'd1);

    // Asynchronous reset in mid-frame, then recovery.
    repeat (5) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_dout", 32'(dout), 32'd0);
    chk("arst_valid", 32'(dout_valid), 32'd0);
    chk("arst_ovr", 32'(overrun), 32'd0);
    dout_ready = 1'b1;
    set_pat(16'hFFFF);
    tick();
    rst_n = 1'b1;
    wait_valid("rec_first", (N + 1) * 16 + 8, cyc);
    chk_rng("rec_flush", cyc, N * 16, (N + 1) * 16 + 3);
    chk("rec_val", 32'(dout), 32'hFFFF);
    wait_valid("rec_next", 24, cyc);
    chk("rec_period", 32'(cyc), 32'd16);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ctdsm_decimator.md
CTDSM_DECIMATOR -- requirements
Module: ctdsm_decimator

Interface
REQ-001 Parameter OUT_W, default 16, meaning output word width in bits.
REQ-002 clk  input  1  single clock, the modulator sampling clock.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 ena  input  1  block enable; 0 freezes all state except the output handshake.
REQ-005 bit_in  input  1  1-bit comparator output from the first-order CT delta-sigma modulator.
REQ-006 dec_sel  input  2  decimation ratio R: 0=16, 1=32, 2=64, 3=128.
REQ-007 dout  output  OUT_W  decimated unsigned sample.
REQ-008 dout_valid  output  1  dout holds an unconsumed sample.
REQ-009 dout_ready  input  1  consumer accepts dout when high with dout_valid.
REQ-010 overrun  output  1  sticky flag: a sample was overwritten unconsumed.
REQ-011 clr_ovr  input  1  synchronous clear of overrun.

Function
REQ-012 bit_in SHALL pass through a 2-flop synchronizer before filtering; it is treated as unipolar 0/1.
REQ-013 Filter SHALL be a CIC of order N (N=3, or 2 per REQ-026): N integrators at clk rate while ena=1, N combs at output rate, differential delay 1.
REQ-014 Integrator/comb width SHALL be 1+3*7 = 22 bits; two's-complement wrap-around in integrators is intended and SHALL NOT saturate.
REQ-015 A decimation counter SHALL count enabled cycles 0..R-1; the comb chain SHALL update on the cycle the counter equals R-1.
REQ-016 Comb result c (range 0..R^N) SHALL scale to OUT_W bits: shift left by OUT_W-N*log2(R) if positive, else right by the difference; the value 2^OUT_W SHALL clip to 2^OUT_W-1.
REQ-017 The scaled word SHALL load into dout, and dout_valid SHALL rise, one clk after the comb update.
REQ-018 After reset, ena rising, or any dec_sel change, the first N comb outputs SHALL be discarded (flush state); dout_valid SHALL NOT assert for them.
REQ-019 A dec_sel change SHALL restart the decimator: clear integrators, combs, and the counter on the next clk, then enter flush.
REQ-020 States: FLUSH (discard count < N) -> RUN after N comb updates; RUN -> FLUSH on dec_sel change or ena fall.
REQ-021 Handshake: dout_valid stays high until a clk with dout_ready=1; dout SHALL be stable while valid and not ready.
REQ-022 New sample while dout_valid=1 and dout_ready=0: dout overwritten, dout_valid stays 1, overrun set.
REQ-023 New sample with dout_ready=1 on the same clk: load new sample, dout_valid stays 1, no overrun.
REQ-024 clr_ovr and an overrun event on the same clk: overrun SHALL end at 1 (set wins).

Reset
REQ-025 rst_n low SHALL asynchronously clear synchronizer, integrators, combs, counter, dout=0, dout_valid=0, overrun=0, and set state FLUSH with discard count 0.

Configuration
REQ-026 Macro CTDSM_DEC_SINC3_EN: defined -> N=3 and 22-bit datapath; undefined -> N=2, 15-bit datapath, third integrator/comb not instantiated; all interface behaviour is otherwise identical.

Structure
REQ-027 Package ctdsm_pkg SHALL hold OUT_W default, CIC order, datapath width, and the dec_sel-to-log2(R) table; ratio-select type is a 2-bit enum there.
REQ-028 Sub-module ctdsm_sync2 SHALL implement the 2-flop synchronizer with async active-low reset; filter and handshake stay in ctdsm_decimator.

Verification
REQ-029 bit_in=1 constant, dec_sel=0, ready=1 -> after flush, every dout=0xFFFF (clip path), one valid every 16 clk.
REQ-030 bit_in=0 constant, dec_sel=3 -> dout=0x0000 every 128 clk, no overrun.
REQ-031 bit_in alternating 1,0, dec_sel=1 -> steady-state dout=0x8000 exactly.
REQ-032 dout_ready=0 across 2 output events -> overrun=1, dout=latest sample; clr_ovr pulse -> overrun=0; REQ-023/024 same-clk cases checked.
REQ-033 dec_sel 0->2 mid-frame -> no dout_valid for next 3 (2 if SINC3 undefined) 64-clk frames, then correct values.
REQ-034 rst_n low mid-frame asynchronously -> all outputs 0 immediately; restart yields flush then REQ-029 values.
